// File: rtl/light_monitor.sv
// Receive-side checker for the 2-bit traffic-light code: tracks G->Y->R->G order,
// measures per-colour dwell time and reports sticky sequence/dwell errors.
module light_monitor #(
    parameter int unsigned GREEN_CYCLES  = 8,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned RED_CYCLES    = 6,
    parameter int unsigned DWELL_W       = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       light_in,
    input  logic             clr_err,
    output logic             in_sync,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic             seq_err,
    output logic             dwell_err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        SYNC,
        TRACK_G,
        TRACK_Y,
        TRACK_R,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        GREEN   = 2'b00,
        YELLOW  = 2'b01,
        RED     = 2'b10,
        INVALID = 2'b11
    } code_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ORDER   = 2'b01,
        ERR_INVALID = 2'b10,
        ERR_DWELL   = 2'b11
    } err_t;

    state_t             state;
    code_t              light_q;
    logic [DWELL_W-1:0] dwell;
    logic               first;

    code_t              cur_colour;
    code_t              next_colour;
    state_t             next_track;
    logic [DWELL_W-1:0] expected;

    always_comb begin
        cur_colour  = GREEN;
        next_colour = YELLOW;
        next_track  = TRACK_Y;
        expected    = DWELL_W'(GREEN_CYCLES);
        case (state)
            TRACK_Y: begin
                cur_colour  = YELLOW;
                next_colour = RED;
                next_track  = TRACK_R;
                expected    = DWELL_W'(YELLOW_CYCLES);
            end
            TRACK_R: begin
                cur_colour  = RED;
                next_colour = GREEN;
                next_track  = TRACK_G;
                expected    = DWELL_W'(RED_CYCLES);
            end
            default: ;
        endcase
    end

    assign in_sync = (state == TRACK_G) || (state == TRACK_Y) || (state == TRACK_R);

    // Error-clear is applied first so that an error detected on the same edge overrides it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            light_q     <= INVALID;
            state       <= SYNC;
            dwell       <= '0;
            first       <= 1'b1;
            cycle_done  <= 1'b0;
            cycle_count <= '0;
            seq_err     <= 1'b0;
            dwell_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            light_q    <= code_t'(light_in);
            cycle_done <= 1'b0;

            if (clr_err) begin
                seq_err   <= 1'b0;
                dwell_err <= 1'b0;
                err_code  <= ERR_NONE;
            end

            case (state)
                SYNC, FAULT: begin
                    if (light_q == GREEN) begin
                        state <= TRACK_G;
                        dwell <= DWELL_W'(1);
                        first <= 1'b1;
                    end
                end
                default: begin
                    if (light_q == cur_colour) begin
                        if (dwell != '1) begin
                            dwell <= dwell + DWELL_W'(1);
                        end
                        // Fires only on the EXPECTED -> EXPECTED+1 step, hence once per phase.
                        if (dwell == expected) begin
                            dwell_err <= 1'b1;
                            err_code  <= ERR_DWELL;
                        end
                    end else if (light_q == next_colour) begin
                        state <= next_track;
                        dwell <= DWELL_W'(1);
                        if ((dwell < expected) && !((state == TRACK_G) && first)) begin
                            dwell_err <= 1'b1;
                            err_code  <= ERR_DWELL;
                        end
                        if (state == TRACK_G) begin
                            first <= 1'b0;
                        end
                        if (state == TRACK_R) begin
                            cycle_done <= 1'b1;
                            if (cycle_count != '1) begin
                                cycle_count <= cycle_count + CNT_W'(1);
                            end
                        end
                    end else begin
                        seq_err  <= 1'b1;
                        err_code <= (light_q == INVALID) ? ERR_INVALID : ERR_ORDER;
                        state    <= FAULT;
                        dwell    <= '0;
                    end
                end
            endcase
        end
    end

endmodule
